// File: rtl/seq_scan_pkg.sv
// Shared types and default sizing for the serial pattern scan controller.
//   PAT_W_DEF   : default maximum pattern length in bits
//   CNT_W_DEF   : default width of match target / match counter
//   scan_state_e: controller state encoding
package seq_scan_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Bus bundle between the scan controller and its user.
//   master: configuration offer, start/abort, serial sample stream in;
//           cfg_ready, detector_out, match_count, busy, done back
//   slave : the controller side of the same signals
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             sample_en;
  logic             sequence_in;
  logic             detector_out;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target,
    output start, abort, sample_en, sequence_in,
    input  cfg_ready, detector_out, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target,
    input  start, abort, sample_en, sequence_in,
    output cfg_ready, detector_out, match_count, busy, done
  );

endinterface

// File: rtl/seq_match_core.sv
// History shift register, saturating fill counter and pattern comparator.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear_i      : wipe history and fill (scan start)
//   sample_i     : shift bit_i into history this cycle
//   bit_i        : serial input bit
//   pattern_i    : latched pattern, bit 0 = most recent bit
//   len_i        : effective pattern length, 1..PAT_W
//   match_c_o    : combinational; bit_i would complete a match if sampled now
// Build option: SEQ_SCAN_OVERLAP_EN keeps fill after a match (overlapping);
// otherwise fill restarts at zero after each match.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic                             sample_i,
  input  logic                             bit_i,
  input  logic [PAT_W-1:0]                 pattern_i,
  input  logic [$clog2(PAT_W):0]           len_i,
  output logic                             match_c_o
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] hist_shift_c;
  logic [PAT_W-1:0] mask_c;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] fill_inc_c;

  // Low len_i bits participate in the comparison.
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (LEN_W'(i) < len_i);
    end
  end

  assign hist_shift_c = PAT_W'({hist_q, bit_i});
  assign fill_inc_c   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);

  // Evaluated against the history as it would look after taking bit_i.
  assign match_c_o = (fill_inc_c >= len_i) &&
                     (((hist_shift_c ^ pattern_i) & mask_c) == '0);

  // Next history / fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (sample_i) begin
      hist_d = hist_shift_c;
`ifdef SEQ_SCAN_OVERLAP_EN
      fill_d = fill_inc_c;
`else
      fill_d = match_c_o ? '0 : fill_inc_c;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scan controller: latches a pattern/length/target, then
// counts matches in a sampled bit stream until the target is reached.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus          : seq_scan_ctrl_if.slave (config, start/abort, samples,
//                  cfg_ready, detector_out, match_count, busy, done)
// Build option: SEQ_SCAN_OVERLAP_EN enables overlapping matches.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  seq_scan_ctrl_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  scan_state_e      state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, det_d;
  logic             rdy_q, busy_q, done_q;

  logic [LEN_W-1:0] len_eff_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             sample_c;
  logic             clear_c;
  logic             match_c;

  // Zero or oversize length selects the full pattern width.
  assign len_eff_c = ((bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(PAT_W)))
                     ? LEN_W'(PAT_W) : bus.cfg_len;

  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Samples only count in SCAN, not on an abort cycle, and never for target 0.
  assign sample_c = (state_q == ST_SCAN) && !bus.abort && (tgt_q != '0) &&
                    bus.sample_en;
  assign clear_c  = (state_q == ST_ARMED) && !bus.abort && bus.start;

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (clear_c),
    .sample_i  (sample_c),
    .bit_i     (bus.sequence_in),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .match_c_o (match_c)
  );

  // Next state and datapath.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.cfg_valid) begin
          pat_d   = bus.cfg_pattern;
          len_d   = len_eff_c;
          tgt_d   = bus.cfg_target;
          cnt_d   = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (tgt_q == '0) begin
          state_d = ST_DONE;
        end else if (sample_c && match_c) begin
          det_d = 1'b1;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == tgt_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; status flags registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      rdy_q   <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_q  <= (state_d == ST_SCAN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.cfg_ready    = rdy_q;
  assign bus.detector_out = det_q;
  assign bus.match_count  = cnt_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl with a scoreboard of expected
// per-sample results. Follows SEQ_SCAN_OVERLAP_EN to pick overlap behaviour.
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic det;
    int   cnt;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit ov;

  // Reference model state
  logic [PAT_W-1:0] m_hist, m_pat;
  int m_fill, m_len, m_cnt, m_tgt;
  bit m_done;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_target  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.sample_en   = 1'b0;
    bus.sequence_in = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"},  32'(bus.cfg_ready), 32'd1);
    check_eq({tag, "_det"},  32'(bus.detector_out), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_cnt"},  32'(bus.match_count), 32'd0);
  endtask

  task automatic go_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input int len,
                           input int tgt);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_target  = CNT_W'(tgt);
    tick();
    bus.cfg_valid = 1'b0;
    m_pat  = pat;
    m_len  = (len == 0 || len > int'(PAT_W)) ? int'(PAT_W) : len;
    m_tgt  = tgt;
    m_cnt  = 0;
    m_done = 1'b0;
    check_eq("cfg_rdy_low", 32'(bus.cfg_ready), 32'd0);
    check_eq("cfg_cnt_clr", 32'(bus.match_count), 32'd0);
  endtask

  task automatic start_scan();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_hist = '0;
    m_fill = 0;
    check_eq("start_busy", 32'(bus.busy), 32'd1);
  endtask

  // Model one sample, push expectation, drive it, pop and compare.
  task automatic feed(input logic b, input string tag);
    exp_t e;
    logic [PAT_W-1:0] mask;
    bit hit;
    hit = 1'b0;
    if (!m_done) begin
      m_hist = PAT_W'({m_hist, b});
      m_fill = (m_fill + 1 > int'(PAT_W)) ? int'(PAT_W) : m_fill + 1;
      mask   = PAT_W'((32'd1 << m_len) - 32'd1);
      hit    = (m_fill >= m_len) && (((m_hist ^ m_pat) & mask) == '0);
      if (hit) begin
        m_cnt++;
        if (!ov) m_fill = 0;
        if (m_cnt == m_tgt) m_done = 1'b1;
      end
    end
    e.det = hit; e.cnt = m_cnt; e.done = m_done;
    exp_q.push_back(e);
    bus.sample_en   = 1'b1;
    bus.sequence_in = b;
    tick();
    bus.sample_en = 1'b0;
    e = exp_q.pop_front();
    check_eq({tag, "_det"},  32'(bus.detector_out), 32'(e.det));
    check_eq({tag, "_cnt"},  32'(bus.match_count), 32'(e.cnt));
    check_eq({tag, "_done"}, 32'(bus.done), 32'(e.done));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'(!e.done));
  endtask

  task automatic feed_seq(input logic [15:0] seq, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      feed(seq[i], tag);
    end
  endtask

  initial begin
`ifdef SEQ_SCAN_OVERLAP_EN
    ov = 1'b1;
`else
    ov = 1'b0;
`endif
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check_reset_vals("post_rst");

    // 1011 / len 4 / target 2, with a new config offered mid-scan.
    configure(8'b0000_1011, 4, 2);
    start_scan();
    begin
      logic [6:0] s;
      s = 7'b1011011;
      for (int i = 6; i >= 0; i--) begin
        if (i == 5) begin
          bus.cfg_valid   = 1'b1;
          bus.cfg_pattern = 8'h00;
          bus.cfg_len     = LEN_W'(2);
          bus.cfg_target  = CNT_W'(1);
        end
        if (i == 3) bus.cfg_valid = 1'b0;
        feed(s[i], "pat1011");
        if (i == 5) check_eq("midscan_rdy", 32'(bus.cfg_ready), 32'd0);
      end
      bus.cfg_valid = 1'b0;
    end
`ifdef SEQ_SCAN_OVERLAP_EN
    check_eq("ov_final_cnt", 32'(bus.match_count), 32'd2);
    check_eq("ov_final_done", 32'(bus.done), 32'd1);
`else
    check_eq("nov_final_cnt", 32'(bus.match_count), 32'd1);
    check_eq("nov_final_busy", 32'(bus.busy), 32'd1);
`endif

    // Abort in SCAN keeps the count and never raises done.
    go_idle();
    configure(8'b0000_0011, 2, 5);
    start_scan();
    feed_seq(16'b11, 2, "abort_pre");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_rdy",  32'(bus.cfg_ready), 32'd1);
    check_eq("abort_cnt",  32'(bus.match_count), 32'd1);
    tick();
    check_eq("abort_cnt_hold", 32'(bus.match_count), 32'd1);

    // Target 0: done one cycle after entering SCAN, samples ignored.
    configure(8'h01, 1, 0);
    start_scan();
    bus.sample_en   = 1'b1;
    bus.sequence_in = 1'b1;
    tick();
    bus.sample_en = 1'b0;
    check_eq("t0_done", 32'(bus.done), 32'd1);
    check_eq("t0_busy", 32'(bus.busy), 32'd0);
    check_eq("t0_det",  32'(bus.detector_out), 32'd0);
    check_eq("t0_cnt",  32'(bus.match_count), 32'd0);

    // Start and abort together in ARMED: abort wins.
    configure(8'b0000_1011, 4, 2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("sa_rdy",  32'(bus.cfg_ready), 32'd1);
    check_eq("sa_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("sa_busy2", 32'(bus.busy), 32'd0);
    check_eq("sa_done2", 32'(bus.done), 32'd0);

    // Reset after 3 of 4 matching bits; restart needs 4 fresh bits.
    configure(8'b0000_1011, 4, 1);
    start_scan();
    feed_seq(16'b101, 3, "rst_pre");
    reset = 1'b1;
    #2;
    check_reset_vals("midrst");
    reset = 1'b0;
    tick();
    check_reset_vals("midrst_after");
    configure(8'b0000_1011, 4, 1);
    start_scan();
    feed_seq(16'b1011, 4, "rst_restart");
    check_eq("restart_done", 32'(bus.done), 32'd1);

    // Length 0 and oversize both mean the full width.
    configure(8'hA5, 0, 1);
    start_scan();
    feed_seq(16'h00A5, 8, "len0");
    check_eq("len0_done", 32'(bus.done), 32'd1);
    configure(8'h3C, 9, 1);
    start_scan();
    feed_seq(16'h003C, 8, "len9");

    // Length 1, pattern 0: matches on each zero until target 3.
    configure(8'h00, 1, 3);
    start_scan();
    feed_seq(16'b10010, 5, "len1");
    check_eq("len1_cnt", 32'(bus.match_count), 32'd3);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of match target and match counter.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cfg_valid  input  1  configuration offer.
REQ-006 Port cfg_ready  output  1  controller accepts configuration; high in IDLE and DONE only.
REQ-007 Port cfg_pattern  input  PAT_W  pattern; bit 0 is the most recently received bit.
REQ-008 Port cfg_len  input  $clog2(PAT_W)+1  pattern length; 0 or >PAT_W means PAT_W.
REQ-009 Port cfg_target  input  CNT_W  number of matches ending the scan.
REQ-010 Port start  input  1  begin scanning from ARMED.
REQ-011 Port abort  input  1  cancel scan, return to IDLE.
REQ-012 Port sample_en  input  1  sequence_in valid this cycle.
REQ-013 Port sequence_in  input  1  serial input bit.
REQ-014 Port detector_out  output  1  one-cycle match pulse.
REQ-015 Port match_count  output  CNT_W  matches since start.
REQ-016 Port busy  output  1  high in SCAN.
REQ-017 Port done  output  1  high in DONE.

Function
REQ-018 Controller SHALL implement states IDLE, ARMED, SCAN, DONE.
REQ-019 IDLE/DONE: cfg_valid && cfg_ready latches pattern, length, target; next state ARMED; match_count cleared.
REQ-020 ARMED: start -> SCAN; abort -> IDLE; abort wins if both high.
REQ-021 SCAN: each sample_en cycle shifts sequence_in into history and increments saturating fill counter.
REQ-022 Match SHALL occur when fill >= length and low `length` history bits equal low `length` pattern bits.
REQ-023 detector_out SHALL pulse in the cycle after the sampling edge completing a match; latency exactly one clock.
REQ-024 match_count SHALL increment with each detector_out pulse and never wrap.
REQ-025 When match_count reaches target, next state DONE; no further matches counted.
REQ-026 target 0: SCAN -> DONE one cycle after entry, count 0, no pulse.
REQ-027 abort in SCAN -> IDLE next cycle; done never asserted; match_count holds value.
REQ-028 sample_en low: history, fill, detector_out unchanged/low; no match evaluated.
REQ-029 cfg_valid outside IDLE/DONE SHALL be ignored; configuration never changes mid-scan.

Reset
REQ-030 Reset SHALL force IDLE, clear history, fill, match_count, latched configuration.
REQ-031 Reset values: cfg_ready 1, detector_out 0, busy 0, done 0, match_count 0.
REQ-032 Reset asserted mid-scan SHALL abandon scan with no pulse on the following cycle.

Configuration
REQ-033 Macro SEQ_SCAN_OVERLAP_EN defined: after a match, history and fill retained (overlapping matches).
REQ-034 Macro undefined: fill cleared on match; next match needs `length` fresh samples (non-overlapping).

Structure
REQ-035 Package seq_scan_pkg SHALL hold the state enumeration and default PAT_W/CNT_W constants.
REQ-036 Sub-module seq_match_core SHALL hold history shift register, fill counter, comparator.

Verification
REQ-037 Pattern 1011, len 4, target 2, overlap on; bits 1,0,1,1,0,1,1 -> pulses after 4th and 7th samples, done, count 2.
REQ-038 Same stimulus, overlap off -> one pulse after 4th sample only; count 1, busy still high.
REQ-039 Target 0 configured then start -> DONE one cycle later, count 0, no pulse.
REQ-040 Abort asserted with start in ARMED -> IDLE, busy never high.
REQ-041 Reset pulsed after 3 of 4 matching bits -> all outputs at reset values; restart needs full 4 fresh bits.
REQ-042 cfg_valid with new pattern during SCAN -> ignored; matches still on original pattern.
